// File: rtl/value_glyph_sched_pkg.sv
// Shared constants, state encoding and helpers for the RGB value glyph overlay.
package value_glyph_pkg;

    localparam int NUM_SLOTS  = 9;
    localparam int NUM_CH     = 3;
    localparam int GLYPH_W    = 16;
    localparam int GLYPH_ROWS = 16;
    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int ROW_W      = $clog2(GLYPH_ROWS);

    // Slot layout: each channel occupies hundreds, tens, units in that order
    localparam int SLOT_RH   = 0;
    localparam int SLOT_GH   = 3;
    localparam int SLOT_BH   = 6;
    localparam int SLOT_BU   = 8;
    localparam int TENS_OFS  = 1;
    localparam int UNITS_OFS = 2;
    localparam int CH_BASE [NUM_CH] = '{SLOT_RH, SLOT_GH, SLOT_BH};

    typedef logic [GLYPH_W-1:0] glyph_row_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_COMMIT
    } fetch_state_t;

    // Leading-zero test: hundreds blank on 0, tens blank only when hundreds is also 0
    function automatic logic lz_blank(input logic [3:0] hund, input logic [3:0] tens,
                                      input logic is_tens);
        if (is_tens)
            return (hund == 4'd0) && (tens == 4'd0);
        return hund == 4'd0;
    endfunction

endpackage

// File: rtl/value_glyph_sched_bcd.sv
// 8-bit binary to 3-digit BCD, one shift-add-3 step per busy cycle.
// Step sequencing (busy/last) comes from a counter shared by all channels.
module bin8_to_bcd_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        busy,
    input  logic        last,
    input  logic [7:0]  din,
    output logic [11:0] bcd,
    output logic [11:0] result
);

    logic [19:0] work;
    logic [19:0] work_nxt;

    function automatic logic [19:0] add3_shift(input logic [19:0] w);
        logic [19:0] t;
        t = w;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign work_nxt = add3_shift(work);
    // Value the committed register takes when the final step completes
    assign result   = work_nxt[19:8];

    // Working shift register: load on start, one double-dabble step per busy cycle
    always_ff @(posedge clk) begin
        if (start)
            work <= {12'd0, din};
        else if (busy)
            work <= work_nxt;
    end

    // Committed BCD only moves when a conversion finishes without being restarted
    always_ff @(posedge clk) begin
        if (clr)
            bcd <= '0;
        else if (busy && last && !start)
            bcd <= result;
    end

endmodule

// File: rtl/value_glyph_sched.sv
// RGB value overlay glyph scheduler: sequential BCD conversion, per-line glyph
// row fetch through one shared ROM port, and a double-buffered pixel lookup.
module value_glyph_sched
    import value_glyph_pkg::*;
#(
    parameter int ROM_LAT  = 0,
    parameter int LZ_BLANK = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               val_load,
    input  logic [7:0]         val_r,
    input  logic [7:0]         val_g,
    input  logic [7:0]         val_b,
    output logic               conv_busy,
    input  logic               line_start,
    input  logic [ROW_W-1:0]   row_sel,
    output logic [3:0]         rom_digit,
    output logic [ROW_W-1:0]   rom_row,
    input  logic [GLYPH_W-1:0] rom_data,
    output logic               fetch_busy,
    output logic               line_done,
    input  logic [SLOT_W-1:0]  pix_slot,
    input  logic [3:0]         pix_col,
    output logic               pix_on,
    output logic               overrun
);

    logic [2:0]           conv_cnt;
    logic                 conv_last;
    logic                 conv_commit;
    logic [7:0]           val_in   [NUM_CH];
    logic [11:0]          bcd_c    [NUM_CH];
    logic [11:0]          res_c    [NUM_CH];
    logic [11:0]          snap_src [NUM_CH];

    fetch_state_t         state, state_nxt;
    logic [SLOT_W-1:0]    slot;
    logic [ROW_W-1:0]     row_q;
    logic [3:0]           snap     [NUM_SLOTS];
    logic [3:0]           snap_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] blank_vec;

    logic                 vld_p0;
    logic [SLOT_W-1:0]    slot_p0;
    logic                 blank_p0;
    logic                 vld_cap;
    logic [SLOT_W-1:0]    slot_cap;
    logic                 blank_cap;

    glyph_row_t           shadow  [NUM_SLOTS];
    glyph_row_t           display [NUM_SLOTS];

    assign val_in[0] = val_r;
    assign val_in[1] = val_g;
    assign val_in[2] = val_b;

    // A reload on the final step wins: no commit, conversion starts over
    assign conv_last   = conv_busy && (conv_cnt == 3'd7);
    assign conv_commit = conv_last && !val_load;

    // Shared conversion sequencer: 8 busy cycles, restarted by any val_load
    always_ff @(posedge clk) begin
        if (clr) begin
            conv_busy <= 1'b0;
            conv_cnt  <= 3'd0;
        end else if (val_load) begin
            conv_busy <= 1'b1;
            conv_cnt  <= 3'd0;
        end else if (conv_busy) begin
            conv_cnt <= conv_cnt + 3'd1;
            if (conv_cnt == 3'd7)
                conv_busy <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bcd
        bin8_to_bcd_seq u_bcd (
            .clk    (clk),
            .clr    (clr),
            .start  (val_load),
            .busy   (conv_busy),
            .last   (conv_last),
            .din    (val_in[c]),
            .bcd    (bcd_c[c]),
            .result (res_c[c])
        );
    end

    // Snapshot source: a commit on the same edge as line_start is seen by the fetch
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            snap_src[c] = conv_commit ? res_c[c] : bcd_c[c];
            snap_nxt[CH_BASE[c]]             = snap_src[c][11:8];
            snap_nxt[CH_BASE[c] + TENS_OFS]  = snap_src[c][7:4];
            snap_nxt[CH_BASE[c] + UNITS_OFS] = snap_src[c][3:0];
        end
    end

    // Per-slot blanking decision from the snapshot; units never blank
    always_comb begin
        blank_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            blank_vec[CH_BASE[c]] = (LZ_BLANK != 0) &&
                lz_blank(snap[CH_BASE[c]], snap[CH_BASE[c] + TENS_OFS], 1'b0);
            blank_vec[CH_BASE[c] + TENS_OFS] = (LZ_BLANK != 0) &&
                lz_blank(snap[CH_BASE[c]], snap[CH_BASE[c] + TENS_OFS], 1'b1);
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (clr)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Fetch FSM next state and status outputs
    always_comb begin
        state_nxt  = state;
        fetch_busy = 1'b1;
        line_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                fetch_busy = 1'b0;
                if (line_start)
                    state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (slot == SLOT_W'(SLOT_BU))
                    state_nxt = (ROM_LAT != 0) ? ST_WAIT : ST_COMMIT;
            end
            ST_WAIT:   state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                line_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Line setup on accepted line_start, then walk the slots; slot parks on the last one
    always_ff @(posedge clk) begin
        if (clr) begin
            slot  <= '0;
            row_q <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)
                snap[s] <= 4'd0;
        end else if (state == ST_IDLE && line_start) begin
            slot  <= '0;
            row_q <= row_sel;
            snap  <= snap_nxt;
        end else if (state == ST_FETCH && slot != SLOT_W'(SLOT_BU)) begin
            slot <= slot + SLOT_W'(1);
        end
    end

    // Sticky overrun: a line_start arrived while the previous line was still in flight
    always_ff @(posedge clk) begin
        if (clr)
            overrun <= 1'b0;
        else if (line_start && state != ST_IDLE)
            overrun <= 1'b1;
    end

    assign rom_digit = snap[slot];
    assign rom_row   = row_q;

    // ---- p0: ROM address issued ----
    assign vld_p0   = (state == ST_FETCH);
    assign slot_p0  = slot;
    assign blank_p0 = blank_vec[slot];

    if (ROM_LAT == 0) begin : g_lat0
        assign vld_cap   = vld_p0;
        assign slot_cap  = slot_p0;
        assign blank_cap = blank_p0;
    end else begin : g_lat1
        logic              vld_p1;
        logic [SLOT_W-1:0] slot_p1;
        logic              blank_p1;

        // ---- p1: registered ROM data valid ----
        always_ff @(posedge clk) begin
            if (clr)
                vld_p1 <= 1'b0;
            else
                vld_p1 <= vld_p0;
        end

        // Slot tag and blank flag follow the address into the ROM's output cycle
        always_ff @(posedge clk) begin
            slot_p1  <= slot_p0;
            blank_p1 <= blank_p0;
        end

        assign vld_cap   = vld_p1;
        assign slot_cap  = slot_p1;
        assign blank_cap = blank_p1;
    end

    // Capture glyph rows into the shadow buffer; blanked slots store a zero row
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                shadow[s] <= '0;
        end else if (vld_cap) begin
            shadow[slot_cap] <= blank_cap ? '0 : rom_data;
        end
    end

    // Display buffer swaps atomically so a visible line never mixes two fetches
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < NUM_SLOTS; s++)
                display[s] <= '0;
        end else if (state == ST_COMMIT) begin
            display <= shadow;
        end
    end

    // Registered pixel lookup; positions past the last slot read as off
    always_ff @(posedge clk) begin
        if (clr)
            pix_on <= 1'b0;
        else if (pix_slot < SLOT_W'(NUM_SLOTS))
            pix_on <= display[pix_slot][pix_col];
        else
            pix_on <= 1'b0;
    end

endmodule

// File: tb/tb_value_glyph_sched.sv
// Directed bench for value_glyph_sched with a model glyph ROM and an address scoreboard.
module tb_value_glyph_sched;

    localparam int ROM_LAT  = 0;
    localparam int LZ_BLANK = 1;

    logic        clk;
    logic        clr;
    logic        val_load;
    logic [7:0]  val_r, val_g, val_b;
    logic        conv_busy;
    logic        line_start;
    logic [3:0]  row_sel;
    logic [3:0]  rom_digit;
    logic [3:0]  rom_row;
    logic [15:0] rom_data;
    logic        fetch_busy;
    logic        line_done;
    logic [3:0]  pix_slot;
    logic [3:0]  pix_col;
    logic        pix_on;
    logic        overrun;

    int          checks = 0;
    int          errors = 0;
    int          m_r, m_g, m_b;
    logic [15:0] exp_disp [9];
    logic [7:0]  exp_q [$];

    value_glyph_sched #(.ROM_LAT(ROM_LAT), .LZ_BLANK(LZ_BLANK)) dut (
        .clk        (clk),
        .clr        (clr),
        .val_load   (val_load),
        .val_r      (val_r),
        .val_g      (val_g),
        .val_b      (val_b),
        .conv_busy  (conv_busy),
        .line_start (line_start),
        .row_sel    (row_sel),
        .rom_digit  (rom_digit),
        .rom_row    (rom_row),
        .rom_data   (rom_data),
        .fetch_busy (fetch_busy),
        .line_done  (line_done),
        .pix_slot   (pix_slot),
        .pix_col    (pix_col),
        .pix_on     (pix_on),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model glyph: never an all-zero row for digits 0..9
    function automatic logic [15:0] glyph(input logic [3:0] d, input logic [3:0] r);
        logic [3:0] d1;
        d1 = d + 4'd1;
        return {d1, r, ~d, r ^ 4'hA};
    endfunction

    if (ROM_LAT == 0) begin : g_rom0
        assign rom_data = glyph(rom_digit, rom_row);
    end else begin : g_rom1
        always @(posedge clk) rom_data <= glyph(rom_digit, rom_row);
    end

    function automatic logic [3:0] digit_of(input int s);
        int v;
        v = (s < 3) ? m_r : (s < 6) ? m_g : m_b;
        if (s % 3 == 0) return 4'(v / 100);
        if (s % 3 == 1) return 4'((v / 10) % 10);
        return 4'(v % 10);
    endfunction

    function automatic logic blank_of(input int s);
        int base;
        base = s - (s % 3);
        if (LZ_BLANK == 0) return 1'b0;
        if (s % 3 == 0) return digit_of(base) == 4'd0;
        if (s % 3 == 1) return (digit_of(base) == 4'd0) && (digit_of(base + 1) == 4'd0);
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input int g, input int b);
        val_r = 8'(r);
        val_g = 8'(g);
        val_b = 8'(b);
        val_load = 1'b1;
        @(negedge clk);
        val_load = 1'b0;
    endtask

    // Counts the busy cycles still ahead, including the current one
    task automatic conv_len(output int n);
        n = 0;
        while (conv_busy && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic sweep(input string tag);
        logic ex;
        for (int s = 0; s < 16; s++) begin
            for (int c = 0; c < 16; c++) begin
                pix_slot = 4'(s);
                pix_col  = 4'(c);
                @(negedge clk);
                ex = 1'b0;
                if (s < 9) ex = exp_disp[s][c];
                chk(tag, pix_on, ex);
            end
        end
    endtask

    // One line fetch: expected ROM addresses queued at line_start, popped per FETCH cycle
    task automatic run_fetch(input logic [3:0] row, input int intrude_at, input int abort_at);
        logic [3:0]  exp_dig [9];
        logic [15:0] nd [9];
        logic [7:0]  e;
        int          n;
        for (int s = 0; s < 9; s++) begin
            exp_dig[s] = digit_of(s);
            nd[s] = blank_of(s) ? 16'h0 : glyph(exp_dig[s], row);
            exp_q.push_back({exp_dig[s], row});
        end
        row_sel    = row;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        row_sel    = ~row;
        for (int i = 0; i < 9; i++) begin
            e = exp_q.pop_front();
            chk("rom_digit", rom_digit, e[7:4]);
            chk("rom_row", rom_row, e[3:0]);
            chk("fetch_busy", fetch_busy, 1);
            line_start = (i == intrude_at);
            if (i == intrude_at) row_sel = row + 4'd1;
            if (i == abort_at) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                exp_q.delete();
                chk("abort_busy", fetch_busy, 0);
                n = 0;
                for (int j = 0; j < 15; j++) begin
                    if (line_done) n++;
                    @(negedge clk);
                end
                chk("abort_no_done", n, 0);
                m_r = 0;
                m_g = 0;
                m_b = 0;
                for (int s = 0; s < 9; s++) exp_disp[s] = 16'h0;
                return;
            end
            @(negedge clk);
        end
        line_start = 1'b0;
        n = 9;
        while (!line_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        // line_done is high in the cycle ending at the edge that registers it
        chk("line_done_lat", n + 1, 10 + ROM_LAT);
        chk("rom_hold", rom_digit, exp_dig[8]);
        @(negedge clk);
        chk("done_pulse", line_done, 0);
        chk("busy_end", fetch_busy, 0);
        for (int s = 0; s < 9; s++) exp_disp[s] = nd[s];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clr = 1'b1;
        val_load = 1'b0;
        val_r = 8'd0;
        val_g = 8'd0;
        val_b = 8'd0;
        line_start = 1'b0;
        row_sel = 4'd0;
        pix_slot = 4'd0;
        pix_col = 4'd0;
        m_r = 0;
        m_g = 0;
        m_b = 0;
        for (int s = 0; s < 9; s++) exp_disp[s] = 16'h0;
        repeat (2) @(negedge clk);
        clr = 1'b0;

        // 1: reset state
        chk("rst_conv_busy", conv_busy, 0);
        chk("rst_rom_digit", rom_digit, 0);
        chk("rst_rom_row", rom_row, 0);
        chk("rst_fetch_busy", fetch_busy, 0);
        chk("rst_line_done", line_done, 0);
        chk("rst_pix_on", pix_on, 0);
        chk("rst_overrun", overrun, 0);
        sweep("rst_pix");

        // 2: conversion length and first fetch (blanked B hundreds/tens)
        load(255, 128, 7);
        conv_len(n);
        chk("conv_len_t2", n, 8);
        m_r = 255;
        m_g = 128;
        m_b = 7;
        run_fetch(4'd3, -1, -1);

        // 3: pixel sweep of the new display
        sweep("pix_t3");

        // 4: restart mid-conversion, then a fetch during busy sees old values
        load(10, 20, 30);
        @(negedge clk);
        @(negedge clk);
        load(99, 150, 4);
        conv_len(n);
        chk("conv_len_restart", n, 8);
        m_r = 99;
        m_g = 150;
        m_b = 4;
        run_fetch(4'd7, -1, -1);
        load(200, 45, 3);
        run_fetch(4'd9, -1, -1);
        chk("conv_idle", conv_busy, 0);
        m_r = 200;
        m_g = 45;
        m_b = 3;
        sweep("pix_t4");

        // line_start on the same edge the conversion commits takes the new digits
        load(61, 5, 250);
        repeat (7) @(negedge clk);
        m_r = 61;
        m_g = 5;
        m_b = 250;
        run_fetch(4'd12, -1, -1);

        // 5: line_start during a fetch is ignored and latches overrun
        chk("overrun_pre", overrun, 0);
        run_fetch(4'd2, 3, -1);
        chk("overrun_set", overrun, 1);
        run_fetch(4'd4, -1, -1);
        chk("overrun_sticky", overrun, 1);

        // 6: clr mid-fetch aborts; a fresh fetch then completes
        run_fetch(4'd6, -1, 4);
        chk("overrun_clr", overrun, 0);
        chk("abort_rom_digit", rom_digit, 0);
        sweep("pix_abort");
        run_fetch(4'd5, -1, -1);
        sweep("pix_fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
